// File: rtl/obstacle_spawn_scheduler_if.sv
// Control/status bundle between the game sequencer, the obstacle datapath and the
// spawn scheduler. The scheduler sits on the slave side.
interface obstacle_spawn_scheduler_if;
  logic        frame_tick;
  logic [1:0]  game_state;
  logic [2:0]  slot_busy;
  logic [2:0]  slot_release;
  logic [3:0]  obs_sel_1;
  logic [3:0]  obs_sel_2;
  logic [3:0]  obs_sel_3;
  logic [15:0] spawn_count;
  logic [1:0]  sched_state;

  modport master (
    output frame_tick,
    output game_state,
    output slot_busy,
    input  slot_release,
    input  obs_sel_1,
    input  obs_sel_2,
    input  obs_sel_3,
    input  spawn_count,
    input  sched_state
  );

  modport slave (
    input  frame_tick,
    input  game_state,
    input  slot_busy,
    output slot_release,
    output obs_sel_1,
    output obs_sel_2,
    output obs_sel_3,
    output spawn_count,
    output sched_state
  );
endinterface

// File: rtl/obstacle_spawn_scheduler.sv
// Frame-paced obstacle launcher: a free-running LFSR picks obstacle types and gap lengths,
// releasing one of three slots at a time. Parameters must keep MIN_GAP + 15*GAP_STEP <= 255.
module obstacle_spawn_scheduler #(
  parameter int unsigned MIN_GAP     = 40,
  parameter int unsigned GAP_STEP    = 4,
  parameter int unsigned FIRST_DELAY = 20,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst,
  obstacle_spawn_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [7:0] MIN_GAP_C     = 8'(MIN_GAP);
  localparam logic [7:0] GAP_STEP_C    = 8'(GAP_STEP);
  localparam logic [7:0] FIRST_DELAY_C = 8'(FIRST_DELAY);

  // Shift-right Fibonacci form: bits 0,2,3,5 are taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic logic [3:0] mod6(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'd0, 4'd6, 4'd12: r = 4'd0;
      4'd1, 4'd7, 4'd13: r = 4'd1;
      4'd2, 4'd8, 4'd14: r = 4'd2;
      4'd3, 4'd9, 4'd15: r = 4'd3;
      4'd4, 4'd10:       r = 4'd4;
      4'd5, 4'd11:       r = 4'd5;
      default:           r = 4'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] lowest_free(input logic [2:0] free);
    logic [2:0] r;
    if (free[0]) begin
      r = 3'b001;
    end else if (free[1]) begin
      r = 3'b010;
    end else if (free[2]) begin
      r = 3'b100;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] lfsr_r;
  logic [7:0]  gap_cnt_r;
  logic [2:0]  pending_r;
  logic [2:0]  release_r;
  logic [3:0]  obs_sel_1_r;
  logic [3:0]  obs_sel_2_r;
  logic [3:0]  obs_sel_3_r;
  logic [15:0] spawn_count_r;

  logic [2:0]  free_s;
  logic [2:0]  pick_s;
  logic        tick_run_s;
  logic [7:0]  gap_next_s;
  logic [2:0]  pend_next_s;
  logic [2:0]  rel_next_s;
  logic [15:0] spawn_next_s;
  logic [3:0]  sel_val_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode from the game sequencer state
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.game_state == 2'b01) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        case (bus.game_state)
          2'b00:   next_state_s = ST_IDLE;
          2'b01:   next_state_s = ST_RUN;
          default: next_state_s = ST_HALT;
        endcase
      end
      ST_HALT: begin
        if (bus.game_state == 2'b00) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HALT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of gap counter, pending flags, release and spawn count
  always_comb begin
    free_s       = ~bus.slot_busy & ~pending_r;
    pick_s       = lowest_free(free_s);
    sel_val_s    = mod6(lfsr_r[3:0]);
    tick_run_s   = 1'b0;
    gap_next_s   = gap_cnt_r;
    pend_next_s  = pending_r;
    rel_next_s   = 3'b000;
    spawn_next_s = spawn_count_r;
    case (state_r)
      ST_IDLE: begin
        gap_next_s   = FIRST_DELAY_C;
        pend_next_s  = 3'b000;
        spawn_next_s = 16'd0;
      end
      ST_RUN: begin
        // A tick arriving on the same edge as leaving RUN is dropped.
        if (next_state_s == ST_RUN) begin
          tick_run_s = bus.frame_tick;
        end else begin
          tick_run_s = 1'b0;
        end
        pend_next_s = pending_r & ~bus.slot_busy;
        if (tick_run_s) begin
          if (gap_cnt_r != 8'd0) begin
            gap_next_s = gap_cnt_r - 8'd1;
          end else if (pick_s != 3'b000) begin
            rel_next_s  = pick_s;
            pend_next_s = (pending_r & ~bus.slot_busy) | pick_s;
            gap_next_s  = MIN_GAP_C + ({4'd0, lfsr_r[7:4]} * GAP_STEP_C);
            if (spawn_count_r == 16'hFFFF) begin
              spawn_next_s = spawn_count_r;
            end else begin
              spawn_next_s = spawn_count_r + 16'd1;
            end
          end else begin
            gap_next_s = 8'd0;
          end
        end else begin
          gap_next_s = gap_cnt_r;
        end
      end
      ST_HALT: begin
        gap_next_s   = gap_cnt_r;
        pend_next_s  = pending_r;
        spawn_next_s = spawn_count_r;
      end
      default: begin
        gap_next_s   = FIRST_DELAY_C;
        pend_next_s  = 3'b000;
        spawn_next_s = 16'd0;
      end
    endcase
  end

  // Free-running LFSR, advancing in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Scheduler datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_r     <= FIRST_DELAY_C;
      pending_r     <= 3'b000;
      release_r     <= 3'b000;
      spawn_count_r <= 16'd0;
      obs_sel_1_r   <= 4'd0;
      obs_sel_2_r   <= 4'd0;
      obs_sel_3_r   <= 4'd0;
    end else begin
      gap_cnt_r     <= gap_next_s;
      pending_r     <= pend_next_s;
      release_r     <= rel_next_s;
      spawn_count_r <= spawn_next_s;
      obs_sel_1_r   <= rel_next_s[0] ? sel_val_s : obs_sel_1_r;
      obs_sel_2_r   <= rel_next_s[1] ? sel_val_s : obs_sel_2_r;
      obs_sel_3_r   <= rel_next_s[2] ? sel_val_s : obs_sel_3_r;
    end
  end

  assign bus.slot_release = release_r;
  assign bus.obs_sel_1    = obs_sel_1_r;
  assign bus.obs_sel_2    = obs_sel_2_r;
  assign bus.obs_sel_3    = obs_sel_3_r;
  assign bus.spawn_count  = spawn_count_r;
  assign bus.sched_state  = state_r;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Directed bench for obstacle_spawn_scheduler: cold start, gap bounds, blocked slots,
// halt/resume, reset during a release and spawn counter saturation.
module tb_obstacle_spawn_scheduler;
  logic clk;
  logic rst;

  obstacle_spawn_scheduler_if bus ();

  obstacle_spawn_scheduler #(
    .MIN_GAP(40), .GAP_STEP(4), .FIRST_DELAY(20), .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] tb_lfsr;
  logic [15:0] cap_lfsr;
  logic [15:0] rel_lfsr;
  logic [2:0]  obs_rel;
  int          n;
  int          exp_n;
  int          exp_obs1;
  int          exp_obs2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting right, seeded on reset
  always @(posedge clk) begin
    if (rst) tb_lfsr <= 16'hACE1;
    else     tb_lfsr <= {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[5], tb_lfsr[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle frame tick starting at a negedge; release is captured the cycle after.
  task automatic tick(input int idle);
    cap_lfsr = tb_lfsr;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    obs_rel = bus.slot_release;
    repeat (idle) @(negedge clk);
  endtask

  task automatic run_to_release(input int idle, input int limit, output int cnt);
    cnt = 0;
    obs_rel = 3'b000;
    while (obs_rel == 3'b000 && cnt < limit) begin
      tick(idle);
      cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.game_state = 2'b00;
    bus.slot_busy  = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_state",   32'(bus.sched_state),  32'd0);
    chk("rst_release", 32'(bus.slot_release), 32'd0);
    chk("rst_spawn",   32'(bus.spawn_count),  32'd0);
    chk("rst_gap",     32'(dut.gap_cnt_r),    32'd20);
    chk("rst_lfsr",    32'(dut.lfsr_r),       32'hACE1);

    // Cold start: first release one cycle after the 21st tick
    bus.game_state = 2'b01;
    @(negedge clk);
    chk("run_entered", 32'(bus.sched_state), 32'd1);
    run_to_release(9, 30, n);
    chk("cold_ticks",   32'(n),       32'd21);
    chk("cold_release", 32'(obs_rel), 32'd1);
    chk("cold_pulse_width", 32'(bus.slot_release), 32'd0);
    rel_lfsr = cap_lfsr;
    exp_obs1 = int'(rel_lfsr[3:0]) % 6;
    chk("cold_obs_sel_1", 32'(bus.obs_sel_1), 32'(exp_obs1));
    chk("cold_obs_range", 32'(bus.obs_sel_1 <= 4'd5), 32'd1);
    chk("cold_spawn",     32'(bus.spawn_count), 32'd1);
    chk("cold_gap_reload", 32'(dut.gap_cnt_r), 32'(40 + 4 * int'(rel_lfsr[7:4])));
    chk("cold_pending",   32'(dut.pending_r), 32'd1);

    // Gap bounds with slot 0 busy for 5 frames after each release
    for (int r = 0; r < 2; r++) begin
      exp_n = 41 + 4 * int'(rel_lfsr[7:4]);
      bus.slot_busy = 3'b001;
      @(negedge clk);
      chk("pending_clear", 32'(dut.pending_r), 32'd0);
      for (int i = 0; i < 5; i++) tick(2);
      bus.slot_busy = 3'b000;
      run_to_release(2, 110, n);
      chk("gap_interval", 32'(n + 5), 32'(exp_n));
      chk("gap_range", 32'((n + 5) >= 41 && (n + 5) <= 101), 32'd1);
      chk("gap_onehot", 32'(obs_rel), 32'd1);
      rel_lfsr = cap_lfsr;
      exp_obs1 = int'(rel_lfsr[3:0]) % 6;
      chk("gap_obs_sel_1", 32'(bus.obs_sel_1), 32'(exp_obs1));
    end
    chk("gap_spawn", 32'(bus.spawn_count), 32'd3);

    // All slots busy when the gap expires, then slot 1 frees up
    exp_n = 40 + 4 * int'(rel_lfsr[7:4]);
    bus.slot_busy = 3'b111;
    n = 0;
    while (dut.gap_cnt_r != 8'd0 && n < 110) begin
      tick(2);
      n++;
    end
    chk("blocked_countdown", 32'(n), 32'(exp_n));
    for (int i = 0; i < 7; i++) begin
      tick(2);
      chk("blocked_no_release", 32'(obs_rel), 32'd0);
    end
    chk("blocked_gap_zero", 32'(dut.gap_cnt_r), 32'd0);
    bus.slot_busy = 3'b101;
    tick(2);
    chk("unblocked_release", 32'(obs_rel), 32'd2);
    chk("release_one_cycle", 32'(bus.slot_release), 32'd0);
    rel_lfsr = cap_lfsr;
    exp_obs2 = int'(rel_lfsr[3:0]) % 6;
    chk("unblocked_obs_sel_2", 32'(bus.obs_sel_2), 32'(exp_obs2));
    chk("unblocked_obs_sel_1", 32'(bus.obs_sel_1), 32'(exp_obs1));
    chk("unblocked_pending", 32'(dut.pending_r), 32'd2);
    chk("unblocked_spawn", 32'(bus.spawn_count), 32'd4);

    // Halt with gap_cnt == 12; tick on the transition edge is ignored
    bus.slot_busy = 3'b000;
    exp_n = 40 + 4 * int'(rel_lfsr[7:4]);
    for (int i = 0; i < exp_n - 12; i++) tick(2);
    chk("pre_halt_gap", 32'(dut.gap_cnt_r), 32'd12);
    bus.game_state = 2'b10;
    tick(2);
    chk("halt_state", 32'(bus.sched_state), 32'd2);
    chk("halt_edge_tick_ignored", 32'(dut.gap_cnt_r), 32'd12);
    for (int i = 0; i < 3; i++) begin
      tick(2);
      chk("halt_no_release", 32'(obs_rel), 32'd0);
    end
    chk("halt_gap_frozen",   32'(dut.gap_cnt_r),   32'd12);
    chk("halt_spawn_frozen", 32'(bus.spawn_count), 32'd4);
    chk("halt_obs_1", 32'(bus.obs_sel_1), 32'(exp_obs1));
    chk("halt_obs_2", 32'(bus.obs_sel_2), 32'(exp_obs2));
    chk("halt_obs_3", 32'(bus.obs_sel_3), 32'd0);
    bus.game_state = 2'b01;
    tick(2);
    chk("halt_ignores_run", 32'(bus.sched_state), 32'd2);
    bus.game_state = 2'b00;
    @(negedge clk);
    chk("halt_to_idle", 32'(bus.sched_state), 32'd0);
    @(negedge clk);
    chk("idle_spawn_clear", 32'(bus.spawn_count), 32'd0);
    chk("idle_gap_reload",  32'(dut.gap_cnt_r),   32'd20);
    chk("idle_pending",     32'(dut.pending_r),   32'd0);
    chk("idle_obs_kept",    32'(bus.obs_sel_1),   32'(exp_obs1));

    // Reset asserted while release=100 is being driven
    bus.slot_busy  = 3'b011;
    bus.game_state = 2'b01;
    @(negedge clk);
    chk("rerun_state", 32'(bus.sched_state), 32'd1);
    for (int i = 0; i < 20; i++) tick(2);
    chk("rerun_gap_zero", 32'(dut.gap_cnt_r), 32'd0);
    tick(0);
    chk("slot2_release", 32'(obs_rel), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", 32'(bus.slot_release), 32'd0);
    chk("mid_rst_state",   32'(bus.sched_state),  32'd0);
    chk("mid_rst_obs_1",   32'(bus.obs_sel_1),    32'd0);
    chk("mid_rst_obs_2",   32'(bus.obs_sel_2),    32'd0);
    chk("mid_rst_obs_3",   32'(bus.obs_sel_3),    32'd0);
    chk("mid_rst_spawn",   32'(bus.spawn_count),  32'd0);
    chk("mid_rst_gap",     32'(dut.gap_cnt_r),    32'd20);
    chk("mid_rst_pending", 32'(dut.pending_r),    32'd0);
    chk("mid_rst_lfsr",    32'(dut.lfsr_r),       32'hACE1);
    rst = 1'b0;

    // Spawn counter saturation
    bus.slot_busy = 3'b000;
    @(negedge clk);
    chk("sat_run_state", 32'(bus.sched_state), 32'd1);
    force dut.spawn_count_r = 16'hFFFE;
    @(negedge clk);
    release dut.spawn_count_r;
    @(negedge clk);
    chk("sat_preload", 32'(bus.spawn_count), 32'hFFFE);
    run_to_release(2, 30, n);
    chk("sat_first_ticks", 32'(n), 32'd21);
    chk("sat_first_release", 32'(obs_rel), 32'd1);
    chk("sat_reach_max", 32'(bus.spawn_count), 32'hFFFF);
    rel_lfsr = cap_lfsr;
    exp_n = 41 + 4 * int'(rel_lfsr[7:4]);
    run_to_release(2, 110, n);
    chk("sat_second_interval", 32'(n), 32'(exp_n));
    chk("sat_second_release", 32'(obs_rel), 32'd2);
    chk("sat_hold", 32'(bus.spawn_count), 32'hFFFF);
    repeat (4) @(negedge clk);
    chk("sat_hold_later", 32'(bus.spawn_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/obstacle_spawn_scheduler.md
OBSTACLE_SPAWN_SCHEDULER -- requirements
Module: obstacle_spawn_scheduler

Interface
REQ-001 Parameters SHALL be: MIN_GAP, default 40, minimum frames between releases. GAP_STEP, default 4, random gap increment. FIRST_DELAY, default 20, frames from IDLE to first release. SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-002 Parameter rule: MIN_GAP + 15*GAP_STEP SHALL be <= 255.
REQ-003 Clock and reset SHALL be one clock, with synchronous, active-high reset.
REQ-004 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- game_state  in  2  00 idle, 01 running, 10 game over, 11 treated as 10.
- slot_busy  in  3  per-slot obstacle on-screen/in-range flag from the obstacle datapath.
- release  out  3  one-cycle launch pulse per slot.
- obs_sel_1, obs_sel_2, obs_sel_3  out  4 each  obstacle type latched for each slot.
- spawn_count  out  16  total releases since leaving IDLE.
- sched_state  out  2  00 IDLE, 01 RUN, 10 HALT.

Function
REQ-005 The block SHALL contain a 16-bit Fibonacci LFSR with taps 16,14,13,11, advancing every clk cycle in all states.
REQ-006 The FSM SHALL follow these transitions:
- IDLE to RUN when game_state==01.
- RUN to HALT when game_state is 10 or 11.
- RUN to IDLE when game_state==00.
- HALT to IDLE when game_state==00.
- HALT ignores game_state==01.
REQ-007 In IDLE, the block SHALL reload gap_cnt (8-bit) with FIRST_DELAY, clear all pending bits, clear spawn_count, and hold release=0.
REQ-008 In HALT, gap_cnt, pending, obs_sel_* and spawn_count SHALL freeze, and release SHALL stay 0.
REQ-009 Slot i SHALL be free when slot_busy[i]==0 and pending[i]==0.
REQ-010 In RUN, on a frame_tick with gap_cnt!=0, gap_cnt SHALL decrement by 1.
REQ-011 In RUN, on a frame_tick with gap_cnt==0 and at least one free slot, the block SHALL release the lowest-index free slot.
REQ-012 A release SHALL, at the next clk edge:
- set release[i]=1 for exactly one cycle;
- load obs_sel_i = lfsr[3:0] mod 6 (range 0..5);
- set pending[i];
- reload gap_cnt = MIN_GAP + lfsr[7:4]*GAP_STEP;
- increment spawn_count, saturating at 16'hFFFF.
REQ-013 On a frame_tick with gap_cnt==0 and no free slot, gap_cnt SHALL stay 0 with no release, and release SHALL occur on the first later frame_tick with a free slot.
REQ-014 At most one release bit SHALL be set per cycle, and release SHALL never be asserted in a cycle not immediately following a sampled frame_tick.
REQ-015 pending[i] SHALL clear on the cycle after slot_busy[i] is sampled high; the release and slot_busy rise may be sampled in the same cycle.
REQ-016 A frame_tick sampled in the same cycle as a state change out of RUN SHALL be ignored.
REQ-017 obs_sel_i SHALL change only on a release of slot i.
REQ-018 frame_tick held high for N cycles SHALL count as N ticks; no edge detection is performed.

Reset
REQ-019 rst SHALL force: sched_state=IDLE, release=000, obs_sel_1..3=0, spawn_count=0, gap_cnt=FIRST_DELAY, pending=000, lfsr=SEED.
REQ-020 rst SHALL take priority over all other inputs, including mid-release; release SHALL be 000 on the cycle after rst is sampled.

Verification
REQ-021 Cold start: rst 2 cycles, game_state=01, slot_busy=000, frame_tick every 10 clk -> first release=001 exactly one cycle after the 21st tick; obs_sel_1 in 0..5; spawn_count=1.
REQ-022 Gap bounds: continuous run with slot_busy mirroring pending and cleared 5 frames after release -> the interval between consecutive releases is 41..101 frames in every instance; release one-hot.
REQ-023 All busy: slot_busy=111 when gap_cnt reaches 0, then slot_busy=101 after 7 further ticks -> no release during the blocked ticks; release=010 after the next tick.
REQ-024 Halt/resume: game_state=10 mid-gap with gap_cnt=12 -> gap_cnt, spawn_count and obs_sel frozen; game_state=01 ignored; then 00 -> IDLE with spawn_count=0 and gap_cnt=20.
REQ-025 Reset mid-operation: rst asserted in the cycle release=100 is driven -> the next cycle shows release=000 and all reset values per REQ-019.
REQ-026 Saturation: force spawn_count to 16'hFFFE, then two releases -> spawn_count=16'hFFFF and holds.
